// File: rtl/dq_burst_sched.sv
// Burst scheduler: accepts rank-qualified read/write commands, times each data window
// after CL/CWL and drives DQ/DQS enables, strobes, beat indices and error pulses.
module dq_burst_sched #(
  parameter int unsigned RANKS  = 2,
  parameter int unsigned BL     = 8,
  parameter int unsigned CL     = 11,
  parameter int unsigned CWL    = 9,
  parameter int unsigned RPRE   = 1,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RANKS-1:0]      cs_n,
  input  logic                  cmd_rd,
  input  logic                  cmd_wr,
  output logic                  dq_oe,
  output logic                  dqs_oe,
  output logic                  dqs_t_o,
  output logic                  dqs_c_o,
  output logic                  rd_req,
  output logic [$clog2(BL)-1:0] rd_beat,
  output logic                  rd_last,
  output logic                  wr_cap,
  output logic [$clog2(BL)-1:0] wr_beat,
  output logic                  wr_last,
  output logic [RANKS-1:0]      rank_oh,
  output logic                  err_cmd,
  output logic                  err_collision,
  output logic                  err_overflow
);

  localparam int unsigned BEAT_W = $clog2(BL);
  localparam int unsigned LMAX   = (CL > CWL) ? CL : CWL;
  localparam int unsigned DLY_W  = $clog2(LMAX + 1);
  localparam int unsigned BUSY_W = $clog2(LMAX + BL);
  localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);

  // Pending entries: q_dly counts cycles until the entry's first data beat.
  logic [QDEPTH-1:0]             q_vld, q_rd, n_vld, n_rd;
  logic [QDEPTH-1:0][RANKS-1:0]  q_rank, n_rank;
  logic [QDEPTH-1:0][DLY_W-1:0]  q_dly, n_dly;
  logic [BUSY_W-1:0]             busy_rem, n_busy, lat;
  logic                          win_act, win_rd, n_act, n_win_rd;
  logic [RANKS-1:0]              win_rank, n_win_rank, cs_low, st_rank;
  logic [BEAT_W-1:0]             beat, n_beat;
  logic [CNT_W-1:0]              pend;
  logic                          any_cs, one_cs, cmd_bad, cmd_ok, collide, full, accept;
  logic                          st, st_rd, placed, pre;

  always_comb begin
    cs_low  = ~cs_n;
    any_cs  = |cs_low;
    one_cs  = any_cs && ((cs_low & (cs_low - RANKS'(1))) == '0);
    cmd_bad = any_cs && (!one_cs || (cmd_rd && cmd_wr));
    cmd_ok  = one_cs && (cmd_rd ^ cmd_wr);
    lat     = cmd_rd ? BUSY_W'(CL) : BUSY_W'(CWL);
    pend    = '0;
    for (int i = 0; i < QDEPTH; i++) pend = pend + CNT_W'(q_vld[i]);
    collide = cmd_ok && (lat <= busy_rem);
    full    = (pend == CNT_W'(QDEPTH));
    accept  = cmd_ok && !collide && !full;

    // Age entries; the one reaching zero opens its data window next cycle.
    st      = 1'b0;
    st_rd   = 1'b0;
    st_rank = '0;
    n_vld   = q_vld;
    n_rd    = q_rd;
    n_rank  = q_rank;
    for (int i = 0; i < QDEPTH; i++) begin
      n_dly[i] = q_dly[i] - DLY_W'(1);
      if (q_vld[i] && (n_dly[i] == '0)) begin
        n_vld[i] = 1'b0;
        st       = 1'b1;
        st_rd    = q_rd[i];
        st_rank  = q_rank[i];
      end
    end

    placed = 1'b0;
    if (accept && (lat == BUSY_W'(1))) begin
      st      = 1'b1;
      st_rd   = cmd_rd;
      st_rank = cs_low;
    end else if (accept) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (!q_vld[i] && !placed) begin
          placed    = 1'b1;
          n_vld[i]  = 1'b1;
          n_rd[i]   = cmd_rd;
          n_rank[i] = cs_low;
          n_dly[i]  = DLY_W'(lat - BUSY_W'(1));
        end
      end
    end

    pre = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (n_vld[i] && n_rd[i] && (n_dly[i] <= DLY_W'(RPRE))) pre = 1'b1;
    end

    // Window tracking; a new start at BL-1 continues seamlessly with beat 0.
    n_act      = 1'b0;
    n_win_rd   = 1'b0;
    n_win_rank = '0;
    n_beat     = '0;
    if (st) begin
      n_act      = 1'b1;
      n_win_rd   = st_rd;
      n_win_rank = st_rank;
    end else if (win_act && (beat != BEAT_W'(BL - 1))) begin
      n_act      = 1'b1;
      n_win_rd   = win_rd;
      n_win_rank = win_rank;
      n_beat     = beat + BEAT_W'(1);
    end

    if (accept)                n_busy = lat + BUSY_W'(BL - 2);
    else if (busy_rem != '0)   n_busy = busy_rem - BUSY_W'(1);
    else                       n_busy = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_vld         <= '0;
      q_rd          <= '0;
      q_rank        <= '0;
      q_dly         <= '0;
      busy_rem      <= '0;
      win_act       <= 1'b0;
      win_rd        <= 1'b0;
      win_rank      <= '0;
      beat          <= '0;
      dq_oe         <= 1'b0;
      dqs_oe        <= 1'b0;
      dqs_t_o       <= 1'b0;
      dqs_c_o       <= 1'b0;
      rd_req        <= 1'b0;
      rd_beat       <= '0;
      rd_last       <= 1'b0;
      wr_cap        <= 1'b0;
      wr_beat       <= '0;
      wr_last       <= 1'b0;
      rank_oh       <= '0;
      err_cmd       <= 1'b0;
      err_collision <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      q_vld         <= n_vld;
      q_rd          <= n_rd;
      q_rank        <= n_rank;
      q_dly         <= n_dly;
      busy_rem      <= n_busy;
      win_act       <= n_act;
      win_rd        <= n_win_rd;
      win_rank      <= n_win_rank;
      beat          <= n_beat;
      dq_oe         <= n_act & n_win_rd;
      rd_req        <= n_act & n_win_rd;
      rd_beat       <= (n_act & n_win_rd) ? n_beat : '0;
      rd_last       <= n_act & n_win_rd & (n_beat == BEAT_W'(BL - 1));
      wr_cap        <= n_act & ~n_win_rd;
      wr_beat       <= (n_act & ~n_win_rd) ? n_beat : '0;
      wr_last       <= n_act & ~n_win_rd & (n_beat == BEAT_W'(BL - 1));
      rank_oh       <= n_win_rank;
      // Preamble only in cycles not already covered by a data window.
      dqs_oe        <= (n_act & n_win_rd) | (pre & ~n_act);
      dqs_t_o       <= n_act & n_win_rd & ~n_beat[0];
      dqs_c_o       <= (n_act & n_win_rd & n_beat[0]) | (pre & ~n_act);
      err_cmd       <= cmd_bad;
      err_collision <= collide;
      err_overflow  <= cmd_ok & ~collide & full;
    end
  end

endmodule

// File: tb/tb_dq_burst_sched.sv
// Bench for dq_burst_sched: directed vector table plus randomized traffic checked
// against an absolute-time schedule model, on a default and a QDEPTH=1 instance.
module tb_dq_burst_sched;

  localparam int NC = 48;
  localparam int NE = NC + 40;

  typedef struct packed {
    logic       dq_oe;
    logic       dqs_oe;
    logic       dqs_t;
    logic       dqs_c;
    logic       rd_req;
    logic [2:0] rd_beat;
    logic       rd_last;
    logic       wr_cap;
    logic [2:0] wr_beat;
    logic       wr_last;
    logic [1:0] rank_oh;
    logic       err_cmd;
    logic       err_col;
    logic       err_ovf;
  } out_t;

  typedef struct {
    int   scen;
    int   inst;
    int   cyc;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cs_n;
  logic       cmd_rd, cmd_wr;

  logic       d0_dq_oe, d0_dqs_oe, d0_dqs_t, d0_dqs_c, d0_rd_req, d0_rd_last;
  logic       d0_wr_cap, d0_wr_last, d0_err_cmd, d0_err_col, d0_err_ovf;
  logic [2:0] d0_rd_beat, d0_wr_beat;
  logic [1:0] d0_rank_oh;
  logic       d1_dq_oe, d1_dqs_oe, d1_dqs_t, d1_dqs_c, d1_rd_req, d1_rd_last;
  logic       d1_wr_cap, d1_wr_last, d1_err_cmd, d1_err_col, d1_err_ovf;
  logic [2:0] d1_rd_beat, d1_wr_beat;
  logic [1:0] d1_rank_oh;

  dq_burst_sched u_dut0 (
    .clk(clk), .reset(reset), .cs_n(cs_n), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .dq_oe(d0_dq_oe), .dqs_oe(d0_dqs_oe), .dqs_t_o(d0_dqs_t), .dqs_c_o(d0_dqs_c),
    .rd_req(d0_rd_req), .rd_beat(d0_rd_beat), .rd_last(d0_rd_last),
    .wr_cap(d0_wr_cap), .wr_beat(d0_wr_beat), .wr_last(d0_wr_last),
    .rank_oh(d0_rank_oh), .err_cmd(d0_err_cmd), .err_collision(d0_err_col),
    .err_overflow(d0_err_ovf)
  );

  dq_burst_sched #(.QDEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .cs_n(cs_n), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .dq_oe(d1_dq_oe), .dqs_oe(d1_dqs_oe), .dqs_t_o(d1_dqs_t), .dqs_c_o(d1_dqs_c),
    .rd_req(d1_rd_req), .rd_beat(d1_rd_beat), .rd_last(d1_rd_last),
    .wr_cap(d1_wr_cap), .wr_beat(d1_wr_beat), .wr_last(d1_wr_last),
    .rank_oh(d1_rank_oh), .err_cmd(d1_err_cmd), .err_collision(d1_err_col),
    .err_overflow(d1_err_ovf)
  );

  always #5 clk = ~clk;

  out_t o0, o1;
  assign o0 = {d0_dq_oe, d0_dqs_oe, d0_dqs_t, d0_dqs_c, d0_rd_req, d0_rd_beat, d0_rd_last,
               d0_wr_cap, d0_wr_beat, d0_wr_last, d0_rank_oh, d0_err_cmd, d0_err_col, d0_err_ovf};
  assign o1 = {d1_dq_oe, d1_dqs_oe, d1_dqs_t, d1_dqs_c, d1_rd_req, d1_rd_beat, d1_rd_last,
               d1_wr_cap, d1_wr_beat, d1_wr_last, d1_rank_oh, d1_err_cmd, d1_err_col, d1_err_ovf};

  // Scenario stimulus, one entry per cycle.
  logic [1:0] s_csn [NC];
  bit         s_rd  [NC];
  bit         s_wr  [NC];
  bit         s_rst [NC];

  // Reference schedule per instance, indexed by absolute cycle.
  bit         m_rdw  [2][NE];
  bit         m_wrw  [2][NE];
  bit         m_pre  [2][NE];
  bit         m_ecmd [2][NE];
  bit         m_ecol [2][NE];
  bit         m_eovf [2][NE];
  int         m_beat [2][NE];
  logic [1:0] m_rank [2][NE];
  int         acc_s  [2][NE];
  int         acc_n  [2];
  int         last_b [2];

  out_t trace [2][NC];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int c, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, got, exp);
    end
  endtask

  function automatic out_t rdb(input int k, input logic [1:0] r);
    out_t o = '0;
    o.dq_oe = 1'b1; o.dqs_oe = 1'b1; o.rd_req = 1'b1;
    o.rd_beat = 3'(k); o.rd_last = (k == 7);
    o.dqs_t = (k % 2 == 0); o.dqs_c = (k % 2 == 1);
    o.rank_oh = r;
    return o;
  endfunction

  function automatic out_t wrb(input int k, input logic [1:0] r);
    out_t o = '0;
    o.wr_cap = 1'b1; o.wr_beat = 3'(k); o.wr_last = (k == 7); o.rank_oh = r;
    return o;
  endfunction

  function automatic out_t pre_o();
    out_t o = '0;
    o.dqs_oe = 1'b1; o.dqs_c = 1'b1;
    return o;
  endfunction

  function automatic out_t err_o(input bit e_cmd, input bit e_col, input bit e_ovf);
    out_t o = '0;
    o.err_cmd = e_cmd; o.err_col = e_col; o.err_ovf = e_ovf;
    return o;
  endfunction

  function automatic vec_t v(input int s, input int m, input int c, input out_t e);
    vec_t r;
    r.scen = s; r.inst = m; r.cyc = c; r.exp = e;
    return r;
  endfunction

  function automatic out_t model_out(input int m, input int c);
    out_t o = '0;
    bit   win = m_rdw[m][c] | m_wrw[m][c];
    if (m_rdw[m][c]) begin
      o.dq_oe = 1'b1; o.rd_req = 1'b1;
      o.rd_beat = 3'(m_beat[m][c]); o.rd_last = (m_beat[m][c] == 7);
      o.dqs_t = (m_beat[m][c] % 2 == 0);
    end
    if (m_wrw[m][c]) begin
      o.wr_cap = 1'b1; o.wr_beat = 3'(m_beat[m][c]); o.wr_last = (m_beat[m][c] == 7);
    end
    if (win) o.rank_oh = m_rank[m][c];
    o.dqs_oe  = m_rdw[m][c] | (m_pre[m][c] & !win);
    o.dqs_c   = o.dqs_oe & !o.dqs_t;
    o.err_cmd = m_ecmd[m][c];
    o.err_col = m_ecol[m][c];
    o.err_ovf = m_eovf[m][c];
    return o;
  endfunction

  task automatic model_clear_from(input int m, input int c0);
    for (int k = c0; k < NE; k++) begin
      m_rdw[m][k] = 0; m_wrw[m][k] = 0; m_pre[m][k] = 0;
      m_ecmd[m][k] = 0; m_ecol[m][k] = 0; m_eovf[m][k] = 0;
      m_beat[m][k] = 0; m_rank[m][k] = 2'b00;
    end
    acc_n[m]  = 0;
    last_b[m] = -1;
  endtask

  // Command in cycle c, judged against the absolute schedule so far.
  task automatic model_step(input int m, input int c, input int qd);
    logic [1:0] low;
    int         nlow, lat, busy, pend, s;
    if (s_rst[c]) begin
      model_clear_from(m, c + 1);
      return;
    end
    low  = ~s_csn[c];
    nlow = $countones(low);
    if (nlow == 0) return;
    if (nlow > 1 || (s_rd[c] && s_wr[c])) begin
      m_ecmd[m][c+1] = 1;
      return;
    end
    if (!s_rd[c] && !s_wr[c]) return;
    lat  = s_rd[c] ? 11 : 9;
    busy = (last_b[m] > c) ? last_b[m] - c : 0;
    pend = 0;
    for (int i = 0; i < acc_n[m]; i++) if (acc_s[m][i] > c) pend++;
    if (lat <= busy) m_ecol[m][c+1] = 1;
    else if (pend >= qd) m_eovf[m][c+1] = 1;
    else begin
      s = c + lat;
      for (int k = 0; k < 8; k++) begin
        m_rdw[m][s+k]  = s_rd[c];
        m_wrw[m][s+k]  = s_wr[c];
        m_beat[m][s+k] = k;
        m_rank[m][s+k] = low;
      end
      if (s_rd[c]) m_pre[m][s-1] = 1;
      last_b[m] = s + 7;
      acc_s[m][acc_n[m]] = s;
      acc_n[m]++;
    end
  endtask

  task automatic clear_scen();
    for (int c = 0; c < NC; c++) begin
      s_csn[c] = 2'b11; s_rd[c] = 0; s_wr[c] = 0; s_rst[c] = 0;
    end
  endtask

  task automatic put(input int c, input logic [1:0] csn, input bit rd, input bit wr);
    s_csn[c] = csn; s_rd[c] = rd; s_wr[c] = wr;
  endtask

  task automatic run_scen(input int id);
    model_clear_from(0, 0);
    model_clear_from(1, 0);
    reset = 1'b1; cs_n = 2'b11; cmd_rd = 1'b0; cmd_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      trace[0][c] = o0;
      trace[1][c] = o1;
      chk($sformatf("model_q4_s%0d", id), c, o0, model_out(0, c));
      chk($sformatf("model_q1_s%0d", id), c, o1, model_out(1, c));
      reset = s_rst[c]; cs_n = s_csn[c]; cmd_rd = s_rd[c]; cmd_wr = s_wr[c];
      model_step(0, c, 4);
      model_step(1, c, 1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs.push_back(v(0, 0, 0, '0));
    vecs.push_back(v(0, 0, 9, '0));
    vecs.push_back(v(0, 0, 10, pre_o()));
    vecs.push_back(v(0, 0, 11, rdb(0, 2'b01)));
    vecs.push_back(v(0, 0, 12, rdb(1, 2'b01)));
    vecs.push_back(v(0, 0, 18, rdb(7, 2'b01)));
    vecs.push_back(v(0, 0, 19, '0));
    vecs.push_back(v(1, 0, 18, rdb(7, 2'b10)));
    vecs.push_back(v(1, 0, 19, rdb(0, 2'b10)));
    vecs.push_back(v(1, 0, 26, rdb(7, 2'b10)));
    vecs.push_back(v(1, 0, 27, '0));
    vecs.push_back(v(2, 0, 5, err_o(0, 1, 0)));
    vecs.push_back(v(2, 0, 13, rdb(2, 2'b01)));
    vecs.push_back(v(2, 0, 19, '0));
    vecs.push_back(v(3, 0, 18, rdb(7, 2'b01)));
    vecs.push_back(v(3, 0, 19, wrb(0, 2'b01)));
    vecs.push_back(v(3, 0, 26, wrb(7, 2'b01)));
    vecs.push_back(v(3, 0, 27, '0));
    vecs.push_back(v(4, 0, 1, err_o(1, 0, 0)));
    vecs.push_back(v(4, 0, 10, '0));
    vecs.push_back(v(4, 0, 11, '0));
    vecs.push_back(v(5, 1, 9, err_o(0, 0, 1)));
    vecs.push_back(v(5, 1, 11, rdb(0, 2'b01)));
    vecs.push_back(v(5, 1, 19, '0));
    vecs.push_back(v(5, 0, 19, rdb(0, 2'b01)));
    vecs.push_back(v(6, 0, 14, rdb(3, 2'b01)));
    vecs.push_back(v(6, 0, 15, '0));
    vecs.push_back(v(6, 0, 16, '0));

    for (int s = 0; s < 7; s++) begin
      clear_scen();
      case (s)
        0: put(0, 2'b10, 1, 0);
        1: begin put(0, 2'b01, 1, 0); put(8, 2'b01, 1, 0); end
        2: begin put(0, 2'b10, 1, 0); put(4, 2'b10, 0, 1); end
        3: begin put(0, 2'b10, 1, 0); put(10, 2'b10, 0, 1); end
        4: put(0, 2'b00, 1, 0);
        5: begin put(0, 2'b10, 1, 0); put(8, 2'b10, 1, 0); end
        default: begin put(0, 2'b10, 1, 0); s_rst[14] = 1; end
      endcase
      run_scen(s);
      foreach (vecs[i]) begin
        if (vecs[i].scen == s)
          chk($sformatf("vec_s%0d_i%0d", s, vecs[i].inst), vecs[i].cyc,
              trace[vecs[i].inst][vecs[i].cyc], vecs[i].exp);
      end
    end

    for (int s = 0; s < 30; s++) begin
      clear_scen();
      for (int c = 0; c < NC; c++) begin
        if ($urandom % 4 == 0) begin
          int r  = int'($urandom % 8);
          int r2 = int'($urandom % 9);
          logic [1:0] csn;
          csn = (r < 4) ? 2'b10 : (r < 7) ? 2'b01 : 2'b00;
          put(c, csn, (r2 < 4) || (r2 == 7), (r2 >= 4) && (r2 != 8));
        end
        s_rst[c] = ($urandom % 60 == 0);
      end
      run_scen(100 + s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
